// File: rtl/tile_game_pkg.sv
// ---------------------------------------------------------------------------
// tile_game_pkg
// Shared definitions for the tile-matching game round logic:
//   - PS2 set-2 scan codes used by the round controller
//   - round state encoding (also exported on tile_round_ctrl.dbg_state)
//   - default board geometry
// No ports (package).
// ---------------------------------------------------------------------------
package tile_game_pkg;

   // PS2 set-2 make codes
   localparam logic [7:0] KEY_W     = 8'h1D;
   localparam logic [7:0] KEY_A     = 8'h1C;
   localparam logic [7:0] KEY_S     = 8'h1B;
   localparam logic [7:0] KEY_D     = 8'h23;
   localparam logic [7:0] KEY_ENTER = 8'h5A;
   localparam logic [7:0] KEY_BREAK = 8'hF0;

   // Default board geometry (both must be powers of 2, at least 2)
   localparam int DEFAULT_GRID_W = 4;
   localparam int DEFAULT_GRID_H = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PICK1   = 3'd1,
      ST_RD1     = 3'd2,
      ST_PICK2   = 3'd3,
      ST_RD2     = 3'd4,
      ST_SHOW    = 3'd5,
      ST_RESOLVE = 3'd6,
      ST_DONE    = 3'd7
   } round_state_e;

endpackage

// File: rtl/ps2_make_filter.sv
// ---------------------------------------------------------------------------
// ps2_make_filter
// Strips PS2 break sequences (F0 xx) and decodes the make codes the round
// controller cares about into one-hot single-cycle pulses.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears break flag)
//   key_data[7:0]    scan-code byte, valid when key_pressed is high
//   key_pressed      one-cycle strobe
//   key_up/down/left/right/select
//                    combinational pulses, high on the strobe cycle of a
//                    matching make code that is not part of a break sequence
// ---------------------------------------------------------------------------
module ps2_make_filter
   import tile_game_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key_data,
   input  logic       key_pressed,
   output logic       key_up,
   output logic       key_down,
   output logic       key_left,
   output logic       key_right,
   output logic       key_select
);

   logic brk_q;
   logic brk_d;
   logic make_valid;

   // A strobed byte after F0 is the released key: swallow it and clear.
   always_comb begin
      brk_d = brk_q;
      if (key_pressed) begin
         if (brk_q) brk_d = 1'b0;
         else       brk_d = (key_data == KEY_BREAK);
      end
   end

   assign make_valid = key_pressed && !brk_q && (key_data != KEY_BREAK);

   assign key_up     = make_valid && (key_data == KEY_W);
   assign key_down   = make_valid && (key_data == KEY_S);
   assign key_left   = make_valid && (key_data == KEY_A);
   assign key_right  = make_valid && (key_data == KEY_D);
   assign key_select = make_valid && (key_data == KEY_ENTER);

   always_ff @(posedge clk) begin
      if (rst) brk_q <= 1'b0;
      else     brk_q <= brk_d;
   end

endmodule

// File: rtl/tile_round_ctrl.sv
// ---------------------------------------------------------------------------
// tile_round_ctrl
// Sequences one round of the tile-matching game: cursor movement from PS2
// keys, two tile selections per move, ROM lookup, a face-up display window,
// match resolution, move/pair counting and end-of-game detection.
//
// Optional feature: define MOVE_LIMIT_EN to end the round (win=0) once
// MAX_MOVES moves have been made without completing the board.
//
// Ports:
//   CLOCK_50          system clock
//   userquit          synchronous active-high reset, dominates all inputs
//   ingameOn          round enable; low forces IDLE (outputs hold)
//   ps2_key_data[7:0] scan-code byte, ps2_key_pressed one-cycle strobe
//   tile_addr         board ROM address; tile_value valid one cycle later
//   tile_value[3:0]   board ROM data
//   cursor_pos        cursor index row*GRID_W+col
//   revealed_mask     face-up tiles (matched or currently selected)
//   matched_mask      tiles already paired
//   move_count[7:0]   completed moves, saturating at 255
//   pairs_found       matched pair count
//   board_dirty       one-cycle pulse when cursor or masks change
//   gameOver, win     levels, high in DONE (win only when board complete)
//   dbg_state[2:0]    current round state (round_state_e encoding)
//
// Handshake: there is no back-pressure. A key is consumed on the single
// cycle ps2_key_pressed is high; keys arriving in states that do not accept
// them are dropped. The ROM is a fixed one-cycle-latency read.
// ---------------------------------------------------------------------------
module tile_round_ctrl
   import tile_game_pkg::*;
#(
   parameter  int GRID_W      = DEFAULT_GRID_W,
   parameter  int GRID_H      = DEFAULT_GRID_H,
   parameter  int SHOW_CYCLES = 50_000_000,
   parameter  int MAX_MOVES   = 32,
   localparam int N           = GRID_W * GRID_H,
   localparam int AW          = $clog2(N)
)(
   input  logic          CLOCK_50,
   input  logic          userquit,
   input  logic          ingameOn,
   input  logic [7:0]    ps2_key_data,
   input  logic          ps2_key_pressed,
   output logic [AW-1:0] tile_addr,
   input  logic [3:0]    tile_value,
   output logic [AW-1:0] cursor_pos,
   output logic [N-1:0]  revealed_mask,
   output logic [N-1:0]  matched_mask,
   output logic [7:0]    move_count,
   output logic [AW-1:0] pairs_found,
   output logic          board_dirty,
   output logic          gameOver,
   output logic          win,
   output logic [2:0]    dbg_state
);

   localparam int CW    = $clog2(GRID_W);
   localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

`ifdef MOVE_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   // ---------------- key decode ----------------
   logic key_up, key_down, key_left, key_right, key_select;

   ps2_make_filter u_filter (
      .clk         (CLOCK_50),
      .rst         (userquit),
      .key_data    (ps2_key_data),
      .key_pressed (ps2_key_pressed),
      .key_up      (key_up),
      .key_down    (key_down),
      .key_left    (key_left),
      .key_right   (key_right),
      .key_select  (key_select)
   );

   // ---------------- state ----------------
   round_state_e     state_q, state_d;
   logic [AW-1:0]    cursor_q, cursor_d;
   logic [AW-1:0]    tile_addr_q, tile_addr_d;
   logic [AW-1:0]    sel1_q, sel1_d;
   logic [AW-1:0]    sel2_q, sel2_d;
   logic [3:0]       val1_q, val1_d;
   logic [3:0]       val2_q, val2_d;
   logic [N-1:0]     revealed_q, revealed_d;
   logic [N-1:0]     matched_q, matched_d;
   logic [7:0]       move_count_q, move_count_d;
   logic [AW-1:0]    pairs_q, pairs_d;
   logic             board_dirty_q, board_dirty_d;
   logic             game_over_q, game_over_d;
   logic             win_q, win_d;
   logic [CNT_W-1:0] show_cnt_q, show_cnt_d;

   // ---------------- cursor arithmetic ----------------
   // Row and column are separate bit fields, so wrapping within a row or
   // column is plain modular add/subtract on that field.
   logic [CW-1:0]    col, col_n;
   logic [AW-CW-1:0] row, row_n;
   logic             move_key;
   logic             limit_hit;

   assign col      = cursor_q[CW-1:0];
   assign row      = cursor_q[AW-1:CW];
   assign move_key = key_up | key_down | key_left | key_right;

   always_comb begin
      col_n = col;
      row_n = row;
      if (key_left)  col_n = col - CW'(1);
      if (key_right) col_n = col + CW'(1);
      if (key_up)    row_n = row - (AW-CW)'(1);
      if (key_down)  row_n = row + (AW-CW)'(1);
   end

   assign limit_hit = LIMIT_EN && ((int'(move_count_q) + 1) == MAX_MOVES);

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d       = state_q;
      cursor_d      = cursor_q;
      sel1_d        = sel1_q;
      sel2_d        = sel2_q;
      val1_d        = val1_q;
      val2_d        = val2_q;
      revealed_d    = revealed_q;
      matched_d     = matched_q;
      move_count_d  = move_count_q;
      pairs_d       = pairs_q;
      board_dirty_d = 1'b0;
      game_over_d   = game_over_q;
      win_d         = win_q;
      show_cnt_d    = show_cnt_q;

      if (state_q != ST_IDLE && !ingameOn) begin
         // Abort: everything visible holds except the end-of-game flags.
         state_d     = ST_IDLE;
         game_over_d = 1'b0;
         win_d       = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ingameOn) begin
                  state_d      = ST_PICK1;
                  cursor_d     = '0;
                  revealed_d   = '0;
                  matched_d    = '0;
                  move_count_d = '0;
                  pairs_d      = '0;
                  game_over_d  = 1'b0;
                  win_d        = 1'b0;
               end
            end

            ST_PICK1, ST_PICK2: begin
               if (move_key) begin
                  cursor_d      = {row_n, col_n};
                  board_dirty_d = 1'b1;
               end else if (key_select && !matched_q[cursor_q]) begin
                  if (state_q == ST_PICK1) begin
                     sel1_d  = cursor_q;
                     state_d = ST_RD1;
                  end else if (cursor_q != sel1_q) begin
                     sel2_d  = cursor_q;
                     state_d = ST_RD2;
                  end
               end
            end

            ST_RD1: begin
               val1_d             = tile_value;
               revealed_d[sel1_q] = 1'b1;
               board_dirty_d      = 1'b1;
               state_d            = ST_PICK2;
            end

            ST_RD2: begin
               val2_d             = tile_value;
               revealed_d[sel2_q] = 1'b1;
               board_dirty_d      = 1'b1;
               show_cnt_d         = CNT_W'(SHOW_CYCLES - 1);
               state_d            = ST_SHOW;
            end

            ST_SHOW: begin
               if (show_cnt_q == '0) state_d = ST_RESOLVE;
               else                  show_cnt_d = show_cnt_q - CNT_W'(1);
            end

            ST_RESOLVE: begin
               move_count_d  = (move_count_q == 8'hFF) ? 8'hFF : move_count_q + 8'd1;
               board_dirty_d = 1'b1;
               state_d       = ST_PICK1;
               if (val1_q == val2_q) begin
                  matched_d[sel1_q] = 1'b1;
                  matched_d[sel2_q] = 1'b1;
                  pairs_d           = pairs_q + AW'(1);
               end else begin
                  revealed_d[sel1_q] = 1'b0;
                  revealed_d[sel2_q] = 1'b0;
               end
               // Board completion outranks the move limit on the same move.
               if (val1_q == val2_q && pairs_q == AW'(N/2 - 1)) begin
                  state_d     = ST_DONE;
                  game_over_d = 1'b1;
                  win_d       = 1'b1;
               end else if (limit_hit) begin
                  state_d     = ST_DONE;
                  game_over_d = 1'b1;
                  win_d       = 1'b0;
               end
            end

            ST_DONE: begin
            end

            default: state_d = ST_IDLE;
         endcase
      end

      // The ROM address follows the cursor so the selected tile's data is
      // already on tile_value in the RD cycle after Enter.
      tile_addr_d = cursor_d;
   end

   // ---------------- registers ----------------
   always_ff @(posedge CLOCK_50) begin
      if (userquit) begin
         state_q       <= ST_IDLE;
         cursor_q      <= '0;
         tile_addr_q   <= '0;
         sel1_q        <= '0;
         sel2_q        <= '0;
         val1_q        <= '0;
         val2_q        <= '0;
         revealed_q    <= '0;
         matched_q     <= '0;
         move_count_q  <= '0;
         pairs_q       <= '0;
         board_dirty_q <= 1'b0;
         game_over_q   <= 1'b0;
         win_q         <= 1'b0;
         show_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         cursor_q      <= cursor_d;
         tile_addr_q   <= tile_addr_d;
         sel1_q        <= sel1_d;
         sel2_q        <= sel2_d;
         val1_q        <= val1_d;
         val2_q        <= val2_d;
         revealed_q    <= revealed_d;
         matched_q     <= matched_d;
         move_count_q  <= move_count_d;
         pairs_q       <= pairs_d;
         board_dirty_q <= board_dirty_d;
         game_over_q   <= game_over_d;
         win_q         <= win_d;
         show_cnt_q    <= show_cnt_d;
      end
   end

   assign tile_addr     = tile_addr_q;
   assign cursor_pos    = cursor_q;
   assign revealed_mask = revealed_q;
   assign matched_mask  = matched_q;
   assign move_count    = move_count_q;
   assign pairs_found   = pairs_q;
   assign board_dirty   = board_dirty_q;
   assign gameOver      = game_over_q;
   assign win           = win_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_tile_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tile_round_ctrl
// Self-checking bench for tile_round_ctrl (4x4 board, SHOW_CYCLES=10).
// The board ROM, cursor position, masks and counters are modelled here with
// plain arithmetic on row/col integers and bit vectors.
// ---------------------------------------------------------------------------
module tb_tile_round_ctrl;
   import tile_game_pkg::*;

   localparam int W    = 4;
   localparam int H    = 4;
   localparam int N    = W * H;
   localparam int SHOW = 10;
   localparam int MAXM = 3;
`ifdef MOVE_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        userquit, ingame_on, key_pressed;
   logic [7:0]  key_data;
   logic [3:0]  tile_value;
   logic [3:0]  tile_addr, cursor_pos, pairs_found;
   logic [15:0] revealed_mask, matched_mask;
   logic [7:0]  move_count;
   logic        board_dirty, game_over, win;
   logic [2:0]  dbg_state;

   logic [3:0]  rom [N];
   always @(posedge clk) tile_value <= rom[tile_addr];

   tile_round_ctrl #(
      .GRID_W(W), .GRID_H(H), .SHOW_CYCLES(SHOW), .MAX_MOVES(MAXM)
   ) dut (
      .CLOCK_50        (clk),
      .userquit        (userquit),
      .ingameOn        (ingame_on),
      .ps2_key_data    (key_data),
      .ps2_key_pressed (key_pressed),
      .tile_addr       (tile_addr),
      .tile_value      (tile_value),
      .cursor_pos      (cursor_pos),
      .revealed_mask   (revealed_mask),
      .matched_mask    (matched_mask),
      .move_count      (move_count),
      .pairs_found     (pairs_found),
      .board_dirty     (board_dirty),
      .gameOver        (game_over),
      .win             (win),
      .dbg_state       (dbg_state)
   );

   // ---------------- reference model state ----------------
   int          m_row, m_col, m_moves, m_pairs;
   logic [15:0] m_rev, m_match;
   bit          m_done;
   int          n_checks = 0;
   int          n_pass   = 0;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [7:0] code);
      key_data    = code;
      key_pressed = 1'b1;
      tick();
      key_pressed = 1'b0;
      key_data    = 8'h00;
   endtask

   // A movement key in a pick state: model moves the cursor with wrap.
   task automatic key_move(input logic [7:0] code);
      press(code);
      if (code == KEY_D) m_col = (m_col + 1) % W;
      if (code == KEY_A) m_col = (m_col + W - 1) % W;
      if (code == KEY_S) m_row = (m_row + 1) % H;
      if (code == KEY_W) m_row = (m_row + H - 1) % H;
      n_checks++;
      if (cursor_pos !== 4'(m_row * W + m_col) || board_dirty !== 1'b1)
         $display("FAIL cursor_key %h: pos=%0d dirty=%b, want pos=%0d dirty=1",
                  code, cursor_pos, board_dirty, m_row * W + m_col);
      else n_pass++;
   endtask

   task automatic move_to(input int t);
      bit fwd_c, fwd_r;
      fwd_c = 1'($urandom_range(0, 1));
      fwd_r = 1'($urandom_range(0, 1));
      while (m_col != t % W) key_move(fwd_c ? KEY_D : KEY_A);
      while (m_row != t / W) key_move(fwd_r ? KEY_S : KEY_W);
   endtask

   task automatic start_round();
      ingame_on = 1'b0;
      tick();
      n_checks++;
      if (dbg_state !== ST_IDLE || game_over !== 1'b0 || win !== 1'b0 ||
          revealed_mask !== m_rev || matched_mask !== m_match ||
          move_count !== 8'(m_moves))
         $display("FAIL abort_hold: st=%0d go=%b win=%b rev=%h match=%h mv=%0d, want st=0 go=0 win=0 rev=%h match=%h mv=%0d",
                  dbg_state, game_over, win, revealed_mask, matched_mask, move_count, m_rev, m_match, m_moves);
      else n_pass++;
      tick();
      ingame_on = 1'b1;
      tick();
      m_row = 0; m_col = 0; m_moves = 0; m_pairs = 0;
      m_rev = '0; m_match = '0; m_done = 1'b0;
      n_checks++;
      if (dbg_state !== ST_PICK1 ||
          {cursor_pos, revealed_mask, matched_mask, move_count, pairs_found, game_over, win} !== '0)
         $display("FAIL round_start: st=%0d pos=%0d rev=%h match=%h mv=%0d pairs=%0d go=%b win=%b, want PICK1 and zeros",
                  dbg_state, cursor_pos, revealed_mask, matched_mask, move_count, pairs_found, game_over, win);
      else n_pass++;
   endtask

   task automatic pick_first(input int a);
      move_to(a);
      press(KEY_ENTER);
      n_checks++;
      if (dbg_state !== ST_RD1 || tile_addr !== 4'(a))
         $display("FAIL pick1_accept: st=%0d addr=%0d, want st=%0d addr=%0d", dbg_state, tile_addr, ST_RD1, a);
      else n_pass++;
      tick();
      m_rev[a] = 1'b1;
      n_checks++;
      if (dbg_state !== ST_PICK2 || revealed_mask !== m_rev || board_dirty !== 1'b1)
         $display("FAIL pick1_reveal: st=%0d rev=%h dirty=%b, want st=%0d rev=%h dirty=1",
                  dbg_state, revealed_mask, board_dirty, ST_PICK2, m_rev);
      else n_pass++;
   endtask

   task automatic pick_second(input int a, input int b);
      move_to(b);
      press(KEY_ENTER);
      tick();
      m_rev[b] = 1'b1;
      n_checks++;
      if (dbg_state !== ST_SHOW || revealed_mask !== m_rev || board_dirty !== 1'b1)
         $display("FAIL pick2_reveal: st=%0d rev=%h dirty=%b, want st=%0d rev=%h dirty=1",
                  dbg_state, revealed_mask, board_dirty, ST_SHOW, m_rev);
      else n_pass++;
      repeat (SHOW) tick();
      n_checks++;
      if (dbg_state !== ST_RESOLVE || revealed_mask !== m_rev || move_count !== 8'(m_moves))
         $display("FAIL show_window: st=%0d rev=%h mv=%0d, want st=%0d rev=%h mv=%0d",
                  dbg_state, revealed_mask, move_count, ST_RESOLVE, m_rev, m_moves);
      else n_pass++;
      tick();
      m_moves = (m_moves == 255) ? 255 : m_moves + 1;
      if (rom[a] == rom[b]) begin
         m_match[a] = 1'b1; m_match[b] = 1'b1; m_pairs++;
      end else begin
         m_rev[a] = 1'b0; m_rev[b] = 1'b0;
      end
      m_done = (m_pairs == N / 2) || (LIM && m_moves == MAXM);
      n_checks++;
      if (revealed_mask !== m_rev || matched_mask !== m_match || move_count !== 8'(m_moves) ||
          pairs_found !== 4'(m_pairs) || board_dirty !== 1'b1 || game_over !== m_done ||
          win !== (m_pairs == N / 2) || dbg_state !== (m_done ? ST_DONE : ST_PICK1))
         $display("FAIL resolve %0d/%0d: rev=%h match=%h mv=%0d pairs=%0d dirty=%b go=%b win=%b st=%0d, want rev=%h match=%h mv=%0d pairs=%0d dirty=1 go=%b win=%b",
                  a, b, revealed_mask, matched_mask, move_count, pairs_found, board_dirty, game_over, win, dbg_state,
                  m_rev, m_match, m_moves, m_pairs, m_done, (m_pairs == N / 2));
      else n_pass++;
   endtask

   task automatic do_move(input int a, input int b);
      pick_first(a);
      pick_second(a, b);
   endtask

   task automatic shuffle_board();
      logic [3:0] v;
      int j;
      for (int i = 0; i < N; i++) rom[i] = 4'(i / 2);
      for (int i = N - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         v = rom[i]; rom[i] = rom[j]; rom[j] = v;
      end
   endtask

   task automatic find_mismatch(output int a, output int b);
      a = 0; b = 0;
      do a = $urandom_range(0, N - 1); while (m_match[a]);
      do b = $urandom_range(0, N - 1); while (m_match[b] || rom[b] == rom[a]);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      userquit = 1'b1; ingame_on = 1'b1;
      key_data = KEY_D; key_pressed = 1'b1;
      tick();
      key_pressed = 1'b0;
      tick();
      n_checks++;
      if (dbg_state !== ST_IDLE ||
          {tile_addr, cursor_pos, revealed_mask, matched_mask, move_count, pairs_found, board_dirty, game_over, win} !== '0)
         $display("FAIL reset_state: st=%0d pos=%0d rev=%h match=%h mv=%0d go=%b, want IDLE and zeros",
                  dbg_state, cursor_pos, revealed_mask, matched_mask, move_count, game_over);
      else n_pass++;
      userquit = 1'b0;
      tick();
      m_row = 0; m_col = 0; m_moves = 0; m_pairs = 0; m_rev = '0; m_match = '0;
      n_checks++;
      if (dbg_state !== ST_PICK1 || {cursor_pos, revealed_mask, matched_mask, move_count, game_over, win} !== '0)
         $display("FAIL reset_start: st=%0d pos=%0d, want st=%0d pos=0", dbg_state, cursor_pos, ST_PICK1);
      else n_pass++;
   endtask

   task automatic test_cursor_wrap();
      int k;
      logic [3:0] pos0;
      repeat (4) key_move(KEY_D);
      key_move(KEY_W);
      n_checks++;
      if (cursor_pos !== 4'd12) $display("FAIL wrap_up: pos=%0d, want 12", cursor_pos);
      else n_pass++;
      key_move(KEY_S);
      tick();
      n_checks++;
      if (board_dirty !== 1'b0) $display("FAIL dirty_pulse: dirty=%b, want 0", board_dirty);
      else n_pass++;
      // break sequence: F0 then the key code must not move the cursor
      pos0 = cursor_pos;
      press(KEY_BREAK);
      press(KEY_D);
      n_checks++;
      if (cursor_pos !== pos0 || board_dirty !== 1'b0)
         $display("FAIL break_code: pos=%0d dirty=%b, want pos=%0d dirty=0", cursor_pos, board_dirty, pos0);
      else n_pass++;
      key_move(KEY_D);
      // random walk, including an unrelated code that must be ignored
      for (int i = 0; i < 16; i++) begin
         k = $urandom_range(0, 4);
         if (k == 4) begin
            pos0 = cursor_pos;
            press(8'h15);
            n_checks++;
            if (cursor_pos !== pos0 || board_dirty !== 1'b0)
               $display("FAIL ignored_code: pos=%0d dirty=%b, want pos=%0d dirty=0", cursor_pos, board_dirty, pos0);
            else n_pass++;
         end else begin
            key_move(k == 0 ? KEY_W : k == 1 ? KEY_A : k == 2 ? KEY_S : KEY_D);
         end
      end
   endtask

   task automatic test_mismatch();
      for (int i = 0; i < N; i++) rom[i] = 4'($urandom_range(4, 15));
      rom[0] = 4'd1; rom[1] = 4'd2;
      start_round();
      do_move(0, 1);
      n_checks++;
      if ({revealed_mask, move_count, pairs_found} !== {16'h0000, 8'd1, 4'd0})
         $display("FAIL mismatch_result: rev=%h mv=%0d pairs=%0d, want rev=0000 mv=1 pairs=0",
                  revealed_mask, move_count, pairs_found);
      else n_pass++;
   endtask

   task automatic test_match_ignored();
      for (int i = 0; i < N; i++) rom[i] = 4'($urandom_range(4, 15));
      rom[0] = 4'd3; rom[5] = 4'd3;
      start_round();
      pick_first(0);
      press(KEY_ENTER);
      n_checks++;
      if (dbg_state !== ST_PICK2 || board_dirty !== 1'b0 || revealed_mask !== 16'h0001)
         $display("FAIL reselect_sel1: st=%0d dirty=%b rev=%h, want st=%0d dirty=0 rev=0001",
                  dbg_state, board_dirty, revealed_mask, ST_PICK2);
      else n_pass++;
      pick_second(0, 5);
      n_checks++;
      if (matched_mask !== 16'h0021 || pairs_found !== 4'd1)
         $display("FAIL match_result: match=%h pairs=%0d, want 0021 pairs=1", matched_mask, pairs_found);
      else n_pass++;
      press(KEY_ENTER);
      n_checks++;
      if (dbg_state !== ST_PICK1 || board_dirty !== 1'b0)
         $display("FAIL select_matched: st=%0d dirty=%b, want st=%0d dirty=0", dbg_state, board_dirty, ST_PICK1);
      else n_pass++;
   endtask

   task automatic test_full_board();
      int a, b, first;
      logic [15:0] match0;
      logic [3:0]  pos0;
      shuffle_board();
      start_round();
      while (!m_done) begin
         if ($urandom_range(0, 2) == 0 && m_pairs < N / 2 - 1) begin
            find_mismatch(a, b);
         end else begin
            first = -1; a = 0; b = 0;
            for (int i = 0; i < N; i++)
               if (!m_match[i] && first < 0) first = i;
            a = first;
            for (int i = 0; i < N; i++)
               if (i != a && rom[i] == rom[a]) b = i;
            if ($urandom_range(0, 1) == 1) begin first = a; a = b; b = first; end
         end
         do_move(a, b);
      end
      if (!LIM) begin
         n_checks++;
         if (game_over !== 1'b1 || win !== 1'b1 || matched_mask !== 16'hFFFF || pairs_found !== 4'd8)
            $display("FAIL full_board: go=%b win=%b match=%h pairs=%0d, want 1 1 FFFF 8",
                     game_over, win, matched_mask, pairs_found);
         else n_pass++;
      end
      // keys are ignored in DONE
      match0 = matched_mask; pos0 = cursor_pos;
      press(KEY_D);
      press(KEY_ENTER);
      n_checks++;
      if (dbg_state !== ST_DONE || cursor_pos !== pos0 || matched_mask !== match0 || board_dirty !== 1'b0)
         $display("FAIL done_frozen: st=%0d pos=%0d match=%h dirty=%b, want st=%0d pos=%0d match=%h dirty=0",
                  dbg_state, cursor_pos, matched_mask, board_dirty, ST_DONE, pos0, match0);
      else n_pass++;
      ingame_on = 1'b0;
      tick();
      n_checks++;
      if (game_over !== 1'b0 || win !== 1'b0 || dbg_state !== ST_IDLE || matched_mask !== match0)
         $display("FAIL leave_done: go=%b win=%b st=%0d match=%h, want 0 0 IDLE %h",
                  game_over, win, dbg_state, matched_mask, match0);
      else n_pass++;
   endtask

   task automatic test_move_limit();
      int a, b;
      shuffle_board();
      start_round();
      repeat (LIM ? MAXM : MAXM + 1) begin
         find_mismatch(a, b);
         do_move(a, b);
      end
      n_checks++;
      if (game_over !== LIM || win !== 1'b0 || dbg_state !== (LIM ? ST_DONE : ST_PICK1))
         $display("FAIL move_limit: go=%b win=%b st=%0d, want go=%b win=0", game_over, win, dbg_state, LIM);
      else n_pass++;
   endtask

   task automatic test_quit_mid_show();
      int a, b;
      shuffle_board();
      start_round();
      find_mismatch(a, b);
      pick_first(a);
      move_to(b);
      press(KEY_ENTER);
      repeat (4) tick();
      userquit = 1'b1;
      tick();
      n_checks++;
      if (dbg_state !== ST_IDLE ||
          {tile_addr, cursor_pos, revealed_mask, matched_mask, move_count, pairs_found, board_dirty, game_over, win} !== '0)
         $display("FAIL quit_mid_show: st=%0d pos=%0d rev=%h mv=%0d, want IDLE and zeros",
                  dbg_state, cursor_pos, revealed_mask, move_count);
      else n_pass++;
      userquit = 1'b0;
      tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      userquit = 1'b1; ingame_on = 1'b0; key_pressed = 1'b0; key_data = 8'h00;
      for (int i = 0; i < N; i++) rom[i] = 4'd0;
      m_done = 1'b0;
      test_reset();
      test_cursor_wrap();
      test_mismatch();
      test_match_ignored();
      test_full_board();
      test_move_limit();
      test_quit_mid_show();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tile_round_ctrl.md
Name: tile_round_ctrl

Overview:
- Sequences one in-game round of the tile-matching game while ingameOn is high.
- Tracks a cursor on a GRID_W x GRID_H board from PS2 make-codes and accepts two tile selections per move.
- Reads tile values from the board ROM, compares them and holds both tiles face-up for a display window. Matched pairs stay revealed; mismatched pairs are hidden again.
- Counts moves and pairs. Raises gameOver to the game-mode FSM when all pairs are found.

Parameters:
- GRID_W, 4, board columns (power of 2).
- GRID_H, 4, board rows (power of 2).
- SHOW_CYCLES, 50_000_000, cycles both selected tiles stay face-up before resolve (1 s at 50 MHz).
- MAX_MOVES, 32, move limit; used only with MOVE_LIMIT_EN.

Ports:
- CLOCK_50  in  1  system clock.
- userquit  in  1  synchronous active-high reset.
- ingameOn  in  1  round enable from the game-mode FSM.
- ps2_key_data  in  8  PS2 scan-code byte.
- ps2_key_pressed  in  1  one-cycle strobe; ps2_key_data is valid on this cycle.
- tile_addr  out  log2(N)  board ROM address; N = GRID_W*GRID_H.
- tile_value  in  4  ROM data, valid one cycle after tile_addr.
- cursor_pos  out  log2(N)  cursor index, row*GRID_W+col.
- revealed_mask  out  N  face-up tiles (matched or currently selected).
- matched_mask  out  N  tiles already paired.
- move_count  out  8  completed moves, saturates at 255.
- pairs_found  out  log2(N)  matched pair count.
- board_dirty  out  1  one-cycle pulse when cursor/masks change (VGA redraw).
- gameOver  out  1  level; high in DONE.
- win  out  1  level; high in DONE when all pairs are found.

Behaviour:
- Reset (userquit=1):
  - All outputs 0; state IDLE; break flag cleared.
  - Reset dominates every other input on the same cycle.
- Key decode:
  - Byte 8'hF0 sets a break flag; the next strobed byte is discarded and the flag is cleared.
  - Make-codes: W=1D up, A=1C left, S=1B down, D=23 right, Enter=5A select.
  - All other codes are ignored.
- Cursor:
  - Wraps within its row or column, e.g. D at col 3 goes to col 0 of the same row.
  - Moves only in PICK1 and PICK2.
- States:
  - IDLE: wait for ingameOn=1. On entry to PICK1, clear masks, counters and the cursor.
  - PICK1: Enter on an unmatched tile latches sel1=cursor and drives tile_addr=cursor -> RD1.
  - RD1: capture val1 from tile_value; set revealed bit of sel1; pulse board_dirty -> PICK2.
  - PICK2: Enter on an unmatched tile other than sel1 latches sel2 and drives tile_addr -> RD2.
  - RD2: capture val2; set revealed bit of sel2; pulse board_dirty; load the show counter with SHOW_CYCLES-1 -> SHOW.
  - SHOW: count down; ignore all keys. At 0 -> RESOLVE.
  - RESOLVE (one cycle):
    - move_count+1 (saturating).
    - If val1==val2: set matched bits; pairs_found+1.
    - Else: clear both revealed bits.
    - Pulse board_dirty.
    - If pairs_found+1 == N/2 on a match -> DONE with win=1; otherwise -> PICK1.
  - DONE: gameOver=1, masks frozen, keys ignored.
- ingameOn=0 in any non-IDLE state -> IDLE next cycle:
  - Outputs hold their last values until the next round start clears them.
  - gameOver and win drop to 0 on leaving DONE.
- Latency:
  - Select to revealed bit: 2 cycles.
  - RD2 to resolve: SHOW_CYCLES+1 cycles.
- Enter on a matched tile, or on sel1 in PICK2: no state change, no board_dirty.

Optional Feature:
- Macro: MOVE_LIMIT_EN.
- Defined: in RESOLVE, if move_count+1 == MAX_MOVES and the board is not complete -> DONE with win=0. Completion on that same move has priority (win=1).
- Undefined: no move limit; MAX_MOVES is unused; DONE is reached only by a full board.

Decomposition:
- Shared package (tile_game_pkg):
  - scan-code constants KEY_W/A/S/D/ENTER/BREAK;
  - state encoding for the round states;
  - GRID_W/GRID_H defaults.
- One sub-module, ps2_make_filter:
  - strips break sequences;
  - outputs decoded one-hot up/down/left/right/select pulses.

Test Plan:
- Reset and start: userquit pulse, then ingameOn=1 -> all outputs 0, cursor_pos=0, state PICK1.
- Cursor wrap: D x4 from pos 0 -> pos 0; W from pos 0 -> pos 12; each move pulses board_dirty. F0,23 -> no movement.
- Mismatch: ROM[0]=1, ROM[1]=2; Enter at 0, D, Enter.
  - revealed_mask=0x0003 during SHOW (SHOW_CYCLES=10).
  - Then revealed_mask=0, move_count=1, pairs_found=0.
- Match plus ignored selects: ROM[0]=ROM[5]=3.
  - Enter at 0, Enter at 0 again -> ignored.
  - Select 5 -> matched_mask=0x0021, pairs_found=1.
  - Later Enter on 5 -> ignored.
- Full board: solve all 8 pairs -> gameOver=1, win=1 on the cycle after the final RESOLVE. ingameOn=0 -> gameOver=0 next cycle.
- MOVE_LIMIT_EN, MAX_MOVES=3: three mismatches -> gameOver=1, win=0. userquit mid-SHOW -> all outputs 0 next cycle.
